// File: rtl/uart_tx_arbiter_pkg.sv
// tama_defs: shared arbiter state encodings, requester indices and defaults
package tama_defs;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCK = 1'b1} arb_state_t;
  localparam int REQ_STATS = 0;
  localparam int REQ_ALERT = 1;
  localparam int REQ_ECHO = 2;
  localparam int REQ_DEBUG = 3;
  localparam int DEFAULT_NUM_REQ = 4;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, search starts just after i_last and wraps
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_pick,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  assign o_any = |i_req;
  assign o_pick = o_any ? (N'(1) << o_idx) : '0;
  // scan from farthest to nearest offset so the nearest requester after i_last wins
  always_comb begin
    o_idx = '0;
    for (int k = N; k >= 1; k--)
      if (i_req[IW'((int'(i_last) + k) % N)]) o_idx = IW'((int'(i_last) + k) % N);
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin frame-locked sharing of the UART TX byte interface (optional ARB_TIMEOUT_EN grant-stall abort)
module uart_tx_arbiter
  import tama_defs::*;
#(
  parameter int          NUM_REQ        = DEFAULT_NUM_REQ,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 aborted
);
  localparam int IW = $clog2(NUM_REQ);
  arb_state_t r_state, w_state_n;
  logic [NUM_REQ-1:0] r_grant, w_grant_n, w_pick;
  logic [IW-1:0] r_idx, w_idx_n, r_last, w_last_n, w_pick_idx;
  logic w_any, w_lock, w_xfer, w_timeout, w_release;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .i_req(req),
    .i_last(r_last),
    .o_pick(w_pick),
    .o_idx(w_pick_idx),
    .o_any(w_any)
  );
  assign w_lock = r_state == ARB_LOCK;
  assign tx_valid = w_lock && req[r_idx];
  assign tx_data = tx_valid ? req_data[{r_idx, 3'b000} +: 8] : 8'h00;
  assign w_xfer = tx_valid && tx_ready;
  assign req_ack = (w_xfer && !reset) ? r_grant : '0;
  assign busy = w_lock;
  assign grant = r_grant;
  assign w_release = w_lock && (!req[r_idx] || (w_xfer && req_last[r_idx]) || w_timeout);
`ifdef ARB_TIMEOUT_EN
  logic [23:0] r_timer;
  assign w_timeout = w_lock && !w_xfer && r_timer == TIMEOUT_CYCLES - 24'd1;
  assign aborted = w_timeout;
  // stall timer: restarts on entering LOCK and on every accepted byte
  always_ff @(posedge clk)
    r_timer <= (reset || !w_lock || w_xfer) ? 24'd0 : r_timer + 24'd1;
`else
  logic w_unused_timeout;
  assign w_timeout = 1'b0;
  assign aborted = 1'b0;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif
  // next state: arbitrate in IDLE, hold the grant in LOCK until last byte, abandon or abort
  always_comb begin
    w_state_n = w_lock ? (w_release ? ARB_IDLE : ARB_LOCK) : (w_any ? ARB_LOCK : ARB_IDLE);
    w_grant_n = w_lock ? (w_release ? '0 : r_grant) : w_pick;
    w_idx_n = w_lock ? r_idx : w_pick_idx;
    w_last_n = w_release ? r_idx : r_last;
  end
  // state register; after reset the search starts at requester 0
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_idx <= '0;
      r_last <= IW'(NUM_REQ - 1);
    end else begin
      r_state <= w_state_n;
      r_grant <= w_grant_n;
      r_idx <= w_idx_n;
      r_last <= w_last_n;
    end
  end
endmodule
